divider_seq: RTL and testbench
==============================

Name: divider_seq

Overview:
- Sequential unsigned restoring divider; the inverse-operation counterpart of the team's multiplier blocks.
- Uses the same start/ready/en handshake, so datapath controllers can drive either unit interchangeably.
- Produces one quotient bit per enabled cycle.
- Sits beside the multipliers in the arithmetic unit.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CHECK_PARAM, 1, when 1: elaboration error if WIDTH < 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  clock enable; when 0, all state and outputs hold.
- start  input  1  request a division; accepted only when ready=1 and en=1.
- dividend  input  WIDTH  numerator; sampled on the accepting edge only.
- divisor  input  WIDTH  denominator; sampled on the accepting edge only.
- ready  output  1  1 = idle, results valid, new start accepted.
- quotient  output  WIDTH  unsigned quotient of last completed operation.
- remainder  output  WIDTH  unsigned remainder of last completed operation.
- div_by_zero  output  1  1 = last completed operation had divisor 0.

Behaviour:
- Reset (async, rst=1): state IDLE; ready=1; quotient=0; remainder=0; div_by_zero=0; counter=0.
  - Reset mid-operation aborts the operation; no partial result is ever exposed.
- States: IDLE, BUSY.
- IDLE -> BUSY on an edge with en=1, start=1, ready=1. That edge:
  - latches dividend into shift register Q and divisor into D;
  - clears partial remainder R (WIDTH+1 bits);
  - loads iteration counter with WIDTH;
  - records (divisor==0);
  - ready goes 0 after the edge.
- BUSY, each edge with en=1, performs one restoring iteration:
  - {R,Q} shifted left 1;
  - T = R - {1'b0,D} (WIDTH+1 bits);
  - if T nonnegative (MSB 0): R=T, Q[0]=1; else Q[0]=0;
  - counter decrements.
- The edge that performs the final (WIDTH-th) iteration also:
  - writes quotient=Q result and remainder=R[WIDTH-1:0];
  - writes div_by_zero = recorded flag;
  - sets ready=1 and returns to IDLE.
- Latency: ready low for exactly WIDTH enabled cycles after the accepting edge. Cycles with en=0 extend this 1:1.
- Outputs quotient/remainder/div_by_zero change only at completion; they hold their previous values throughout BUSY.
- start while BUSY: ignored, no effect on the operation or outputs.
- start held high across completion: a new operation is accepted on the first edge with ready=1, en=1. Back-to-back operations therefore lose one idle cycle.
- Divide by zero: no special path; same latency. The algorithm yields quotient = all ones and remainder = dividend. div_by_zero=1 for that result.
- en=0 in IDLE with start=1: not accepted.
- Arithmetic is unsigned only. The subtractor is WIDTH+1 bits so no overflow is possible. Invariant: remainder < divisor when divisor != 0.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, en=1 -> ready=0 for 8 cycles, then quotient=14, remainder=2, div_by_zero=0, ready=1.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=3, divisor=200 -> quotient=0, remainder=3.
- dividend=5, divisor=0 -> after 8 cycles: quotient=255, remainder=5, div_by_zero=1. Next op 10/3 -> quotient=3, remainder=1, div_by_zero=0.
- 100/7 with en=0 for 3 cycles mid-BUSY -> ready low for 11 cycles total, quotient=14, remainder=2; outputs frozen during stalls.
- Pulse start with 9/2 at BUSY cycle 4 of 100/7 -> ignored; result 14/2. Outputs keep the prior result until completion.
- Assert rst at BUSY cycle 5 of 100/7 -> immediately ready=1, quotient=0, remainder=0, div_by_zero=0. A following 50/6 yields quotient=8, remainder=2.

Source files
------------

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per enabled cycle,
// sharing the start/ready/en handshake used by the multiplier blocks.
module divider_seq #(
  parameter int WIDTH       = 8,
  parameter int CHECK_PARAM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (CHECK_PARAM == 1 && WIDTH < 2) begin : g_width_check
      $error("divider_seq: WIDTH must be at least 2");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

  // A restored remainder is always below the divisor, so it fits in WIDTH
  // bits between iterations; only the shifted value needs the extra bit.
  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    trial   = r_shift - {1'b0, d_q};

    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            q_d     = dividend;
            d_d     = divisor;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            zero_d  = (divisor == '0);
            state_d = BUSY;
          end
        end
        BUSY: begin
          q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
          r_d   = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quo_d   = q_d;
            rem_d   = r_d;
            dbz_d   = zero_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed literal cases plus a randomized run checked
// every cycle against an arithmetic (/, %) model with a latency countdown.
module tb_divider_seq;

  localparam int W = 8;
  localparam int ALL_ONES = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  divider_seq #(.WIDTH(W), .CHECK_PARAM(1)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .ready(ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Model: result known from plain arithmetic at acceptance, published after
  // WIDTH enabled edges.
  bit m_ready = 1'b1;
  int m_q = 0, m_r = 0, m_z = 0;
  int p_q = 0, p_r = 0, p_z = 0;
  int m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b1;
      m_q = 0; m_r = 0; m_z = 0; m_left = 0;
    end else if (en) begin
      if (m_ready) begin
        if (start) begin
          if (divisor == 0) begin
            p_q = ALL_ONES; p_r = int'(dividend); p_z = 1;
          end else begin
            p_q = int'(dividend) / int'(divisor);
            p_r = int'(dividend) % int'(divisor);
            p_z = 0;
          end
          m_left  = W;
          m_ready = 1'b0;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_q = p_q; m_r = p_r; m_z = p_z;
          m_ready = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model_ready", int'(ready), int'(m_ready));
      checkOutput("model_quotient", int'(quotient), m_q);
      checkOutput("model_remainder", int'(remainder), m_r);
      checkOutput("model_div_by_zero", int'(div_by_zero), m_z);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitReady(inout int cycles);
    while (!ready && cycles < 100) begin
      step(1);
      cycles++;
    end
  endtask

  task automatic applyStimulus(input int a, input int b, output int cycles);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    step(1);
    start  = 1'b0;
    cycles = 0;
    waitReady(cycles);
  endtask

  task automatic checkResult(input string name, input int cyc, input int q,
                             input int r, input int z);
    checkOutput({name, "_latency"}, cyc, W);
    checkOutput({name, "_quotient"}, int'(quotient), q);
    checkOutput({name, "_remainder"}, int'(remainder), r);
    checkOutput({name, "_div_by_zero"}, int'(div_by_zero), z);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    rst = 1'b1; en = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    step(2);
    rst = 1'b0;
    checkOutput("reset_ready", int'(ready), 1);
    checkOutput("reset_quotient", int'(quotient), 0);
    checkOutput("reset_remainder", int'(remainder), 0);
    checkOutput("reset_div_by_zero", int'(div_by_zero), 0);

    en = 1'b0; start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    step(2);
    checkOutput("idle_en0_not_accepted", int'(ready), 1);
    start = 1'b0; en = 1'b1;

    applyStimulus(100, 7, cyc);  checkResult("div_100_7", cyc, 14, 2, 0);
    applyStimulus(255, 1, cyc);  checkResult("div_255_1", cyc, 255, 0, 0);
    applyStimulus(3, 200, cyc);  checkResult("div_3_200", cyc, 0, 3, 0);
    applyStimulus(5, 0, cyc);    checkResult("div_5_0", cyc, 255, 5, 1);
    applyStimulus(10, 3, cyc);   checkResult("div_10_3", cyc, 3, 1, 0);

    // Three stalled cycles in the middle of BUSY
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    en = 1'b0;
    step(3);
    checkOutput("stall_frozen_quotient", int'(quotient), 3);
    checkOutput("stall_frozen_ready", int'(ready), 0);
    en = 1'b1;
    cyc = 5;
    waitReady(cyc);
    checkOutput("stall_latency", cyc, 11);
    checkOutput("stall_quotient", int'(quotient), 14);
    checkOutput("stall_remainder", int'(remainder), 2);

    applyStimulus(20, 6, cyc);   checkResult("div_20_6", cyc, 3, 2, 0);

    // start pulse with new operands while BUSY is ignored
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    dividend = 8'd9; divisor = 8'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    checkOutput("busy_hold_quotient", int'(quotient), 3);
    checkOutput("busy_hold_remainder", int'(remainder), 2);
    cyc = 4;
    waitReady(cyc);
    checkResult("busy_start_ignored", cyc, 14, 2, 0);

    // Reset in the middle of an operation
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", int'(ready), 1);
    checkOutput("abort_quotient", int'(quotient), 0);
    checkOutput("abort_remainder", int'(remainder), 0);
    checkOutput("abort_div_by_zero", int'(div_by_zero), 0);
    rst = 1'b0;
    step(1);
    applyStimulus(50, 6, cyc);   checkResult("div_50_6", cyc, 8, 2, 0);

    // Randomized traffic: en gaps, start while busy, start held over completion
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      step(1);
    end
    en = 1'b1; start = 1'b0;
    cyc = 0;
    waitReady(cyc);
    checkOutput("final_ready", int'(ready), 1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
